// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, pixel field widths and FSM state encoding for the VGA plot path
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_BITS = 8;
  localparam int Y_BITS = 7;
  localparam int COLOUR_BITS = 3;
  localparam logic [COLOUR_BITS-1:0] COLOUR_BLACK = 3'b000;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DRAW = 2'd2, S_DONE = 2'd3} state_t;
endpackage

// File: rtl/vga_plot_arbiter_rect_walker.sv
// rect_walker: raster offset counters over a (w+1)x(h+1) rectangle, x offset fastest
module rect_walker #(
  parameter int SZ_BITS = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               step,
  input  logic [SZ_BITS-1:0] w,
  input  logic [SZ_BITS-1:0] h,
  output logic               wrap,
  output logic               last
);
  logic [SZ_BITS-1:0] ox, oy;
  assign wrap = ox == w;
  assign last = wrap && oy == h;
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      ox <= '0;
      oy <= '0;
    end else if (step) begin
      ox <= wrap ? '0 : ox + 1'b1;
      oy <= wrap ? oy + 1'b1 : oy;
    end
  end
endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin shares the vga_adapter write port, rastering one rectangle per grant.
// Define VGA_PLOT_CLIP_EN to suppress plot for pixels falling off the 160x120 screen.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int SZ_BITS = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_BITS-1:0]    rect_x,
  input  logic [NUM_REQ*Y_BITS-1:0]    rect_y,
  input  logic [NUM_REQ*SZ_BITS-1:0]   rect_w,
  input  logic [NUM_REQ*SZ_BITS-1:0]   rect_h,
  input  logic [NUM_REQ*COLOUR_BITS-1:0] rect_colour,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [X_BITS-1:0]            x,
  output logic [Y_BITS-1:0]            y,
  output logic [COLOUR_BITS-1:0]       colour,
  output logic                         plot
);
  localparam int PW = $clog2(NUM_REQ);
`ifdef VGA_PLOT_CLIP_EN
  localparam int XW = X_BITS + 1;
  localparam int YW = Y_BITS + 1;
`else
  localparam int XW = X_BITS;
  localparam int YW = Y_BITS;
`endif
  state_t state, nstate;
  logic [PW-1:0] rr, win, pick;
  logic [X_BITS-1:0] x0, sel_x;
  logic [Y_BITS-1:0] sel_y;
  logic [SZ_BITS-1:0] w_r, h_r, sel_w, sel_h;
  logic [COLOUR_BITS-1:0] sel_c;
  logic [XW-1:0] ux, nux;
  logic [YW-1:0] uy, nuy;
  logic wrap, last, adv, vis;
  // first requester at or above the rr pointer, modulo NUM_REQ
  always_comb begin
    pick = rr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(rr) + i) % NUM_REQ]) pick = PW'((int'(rr) + i) % NUM_REQ);
  end
  assign sel_x = rect_x[int'(win)*X_BITS +: X_BITS];
  assign sel_y = rect_y[int'(win)*Y_BITS +: Y_BITS];
  assign sel_w = rect_w[int'(win)*SZ_BITS +: SZ_BITS];
  assign sel_h = rect_h[int'(win)*SZ_BITS +: SZ_BITS];
  assign sel_c = rect_colour[int'(win)*COLOUR_BITS +: COLOUR_BITS];
  rect_walker #(.SZ_BITS(SZ_BITS)) u_walker (
    .clk   (clk),
    .resetn(resetn),
    .start (state == S_LOAD),
    .step  (state == S_DRAW),
    .w     (w_r),
    .h     (h_r),
    .wrap  (wrap),
    .last  (last)
  );
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else state <= nstate;
  end
  always_comb begin
    nstate = state == S_IDLE ? (|req ? S_LOAD : S_IDLE) :
             state == S_LOAD ? S_DRAW :
             state == S_DRAW ? (last ? S_DONE : S_DRAW) : S_IDLE;
  end
  always_comb begin
    gnt  = (state == S_LOAD || state == S_DRAW) ? NUM_REQ'(1) << win : '0;
    done = state == S_DONE ? NUM_REQ'(1) << win : '0;
    busy = state == S_LOAD || state == S_DRAW;
  end
  // pixel coordinates are kept unwrapped when clipping so off-screen pixels can be detected
  assign adv = state == S_LOAD || (state == S_DRAW && !last);
  assign nux = state == S_LOAD ? XW'(sel_x) : wrap ? XW'(x0) : ux + 1'b1;
  assign nuy = state == S_LOAD ? YW'(sel_y) : wrap ? uy + 1'b1 : uy;
`ifdef VGA_PLOT_CLIP_EN
  assign vis = nux < XW'(SCREEN_W) && nuy < YW'(SCREEN_H);
`else
  assign vis = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr <= '0;
      win <= '0;
      x0 <= '0;
      w_r <= '0;
      h_r <= '0;
      colour <= '0;
      ux <= '0;
      uy <= '0;
      plot <= 1'b0;
    end else begin
      if (state == S_IDLE) win <= pick;
      if (state == S_LOAD) begin
        x0 <= sel_x;
        w_r <= sel_w;
        h_r <= sel_h;
        colour <= sel_c;
      end
      if (state == S_DONE) rr <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
      if (adv) begin
        ux <= nux;
        uy <= nuy;
      end
      plot <= adv && vis;
    end
  end
  assign x = ux[X_BITS-1:0];
  assign y = uy[Y_BITS-1:0];
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed checks of arbitration order, raster output, reset abort and req drop
module tb_vga_plot_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [2:0] req = '0;
  logic [23:0] rect_x = '0;
  logic [20:0] rect_y = '0;
  logic [11:0] rect_w = '0, rect_h = '0;
  logic [8:0] rect_colour = '0;
  logic [2:0] gnt, done, colour;
  logic busy, plot;
  logic [7:0] x;
  logic [6:0] y;
  int n_chk = 0, n_fail = 0;
  int np, cyc;
  logic [7:0] fx, lx;
  logic [6:0] fy, ly;
  logic [2:0] g, d;

  vga_plot_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .rect_x(rect_x), .rect_y(rect_y),
    .rect_w(rect_w), .rect_h(rect_h), .rect_colour(rect_colour), .gnt(gnt), .done(done),
    .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rect(input int c, input int rx, input int ry, input int rw, input int rh, input int rc);
    rect_x[c*8 +: 8] = 8'(rx);
    rect_y[c*7 +: 7] = 7'(ry);
    rect_w[c*4 +: 4] = 4'(rw);
    rect_h[c*4 +: 4] = 4'(rh);
    rect_colour[c*3 +: 3] = 3'(rc);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = '0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // runs until done pulses (bounded), collecting plot statistics; owner drops req on done
  task automatic serve(output int n, output logic [7:0] ax, output logic [6:0] ay,
                       output logic [7:0] bx, output logic [6:0] by,
                       output logic [2:0] gg, output logic [2:0] dd, output int c);
    n = 0; gg = '0; dd = '0; c = 0; ax = '0; ay = '0; bx = '0; by = '0;
    while (dd == '0 && c < 400) begin
      step();
      c++;
      if (gnt != '0) gg = gnt;
      if (plot) begin
        if (n == 0) begin ax = x; ay = y; end
        bx = x; by = y;
        n++;
      end
      if (done != '0) dd = done;
    end
    req = req & ~dd;
  endtask

  initial begin
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_plot", plot, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);

    // 1: client1 2x1 at (10,20)
    set_rect(1, 10, 20, 1, 0, 5);
    req = 3'b010;
    step();
    check("t1_load_gnt", gnt, 3'b010);
    check("t1_load_busy", busy, 1);
    check("t1_load_plot", plot, 0);
    step();
    check("t1_p0_plot", plot, 1);
    check("t1_p0_x", x, 10);
    check("t1_p0_y", y, 20);
    check("t1_p0_colour", colour, 5);
    step();
    check("t1_p1_x", x, 11);
    check("t1_p1_plot", plot, 1);
    step();
    check("t1_done", done, 3'b010);
    check("t1_done_plot", plot, 0);
    check("t1_done_gnt", gnt, 0);
    req = '0;
    step();
    check("t1_idle_done", done, 0);

    // 2: round robin from reset
    do_reset();
    set_rect(0, 1, 1, 0, 0, 1);
    set_rect(1, 2, 2, 0, 0, 2);
    set_rect(2, 3, 3, 0, 0, 3);
    req = 3'b111;
    serve(np, fx, fy, lx, ly, g, d, cyc);
    check("t2_g0", g, 3'b001);
    check("t2_d0", d, 3'b001);
    check("t2_cyc0", cyc, 3);
    serve(np, fx, fy, lx, ly, g, d, cyc);
    check("t2_g1", g, 3'b010);
    check("t2_x1", lx, 2);
    check("t2_cyc1", cyc, 4);
    req = 3'b011;
    serve(np, fx, fy, lx, ly, g, d, cyc);
    check("t2_g_wrap", g, 3'b001);
    check("t2_np", np, 1);

    // 3: paddle 16x4 at (80,100)
    do_reset();
    set_rect(0, 80, 100, 15, 3, 7);
    req = 3'b001;
    serve(np, fx, fy, lx, ly, g, d, cyc);
    check("t3_np", np, 64);
    check("t3_fx", fx, 80);
    check("t3_fy", fy, 100);
    check("t3_lx", lx, 95);
    check("t3_ly", ly, 103);
    check("t3_cyc", cyc, 66);
    check("t3_done", d, 3'b001);
    check("t3_busy_done", busy, 0);
    step();
    check("t3_busy_idle", busy, 0);

    // 4: right-edge rectangles
    set_rect(2, 150, 5, 15, 0, 4);
    req = 3'b100;
    serve(np, fx, fy, lx, ly, g, d, cyc);
    check("t4_cyc", cyc, 18);
    check("t4_g", g, 3'b100);
`ifdef VGA_PLOT_CLIP_EN
    check("t4_np", np, 10);
    check("t4_lx", lx, 159);
`else
    check("t4_np", np, 16);
    check("t4_lx", lx, 165);
`endif
    set_rect(2, 250, 5, 15, 0, 4);
    req = 3'b100;
    serve(np, fx, fy, lx, ly, g, d, cyc);
    check("t4w_cyc", cyc, 19);
`ifdef VGA_PLOT_CLIP_EN
    check("t4w_np", np, 0);
`else
    check("t4w_np", np, 16);
    check("t4w_fx", fx, 250);
    check("t4w_lx", lx, 9);
`endif

    // 5: reset mid-draw, rr pointer returns to 0
    do_reset();
    set_rect(0, 60, 60, 0, 0, 1);
    req = 3'b001;
    serve(np, fx, fy, lx, ly, g, d, cyc);
    set_rect(1, 20, 30, 15, 3, 3);
    req = 3'b010;
    for (int i = 0; i < 7; i++) step();
    check("t5_p5_plot", plot, 1);
    check("t5_p5_x", x, 24);
    check("t5_p5_y", y, 30);
    check("t5_p5_colour", colour, 3);
    resetn = 1'b0;
    req = '0;
    step();
    check("t5_rst_plot", plot, 0);
    check("t5_rst_gnt", gnt, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_busy", busy, 0);
    resetn = 1'b1;
    req = 3'b111;
    serve(np, fx, fy, lx, ly, g, d, cyc);
    check("t5_rr_g", g, 3'b001);
    check("t5_rr_np", np, 1);

    // 6: client0 drops req mid-draw
    req = '0;
    set_rect(0, 30, 40, 3, 0, 2);
    req = 3'b001;
    step();
    step();
    step();
    check("t6_p0_plot", plot, 1);
    check("t6_p0_x", x, 30);
    req = '0;
    serve(np, fx, fy, lx, ly, g, d, cyc);
    check("t6_np", np + 1, 4);
    check("t6_lx", lx, 33);
    check("t6_done", d, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
